// File: rtl/mat_result_collector.sv
// Captures the element-serial result stream of mat_ops, validates it, and replays the stored
// matrix row-major over a valid/ready handshake.
module mat_result_collector #(
  parameter int unsigned MAX_ELEMS = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       busy_flag,
  input  logic       op_done,
  input  logic       error_flag,
  input  logic [7:0] result_data,
  input  logic [2:0] result_m,
  input  logic [2:0] result_n,
  input  logic       rd_start,
  input  logic       rd_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic [2:0] rd_row,
  output logic [2:0] rd_col,
  output logic       rd_last,
  output logic [2:0] res_m,
  output logic [2:0] res_n,
  output logic [4:0] elem_count,
  output logic       result_valid,
  output logic       ovf_flag,
  output logic       mismatch_flag,
  output logic       err_flag
);

  typedef enum logic [1:0] {StIdle, StCapture, StHold, StRead} state_e;

  state_e state_q, state_d;

  logic [7:0] mem_q [MAX_ELEMS];
  logic       mem_we;
  logic [4:0] mem_addr;

  logic       wr;
  logic       enter_cap;
  logic       replay_go;
  logic       consume;
  logic       mismatch;
  logic [5:0] product;

  logic [4:0] elem_count_d, elem_count_q;
  logic       result_valid_d, result_valid_q;
  logic       ovf_d, ovf_q;
  logic       mismatch_d, mismatch_q;
  logic       err_d, err_q;
  logic [2:0] res_m_d, res_m_q;
  logic [2:0] res_n_d, res_n_q;
  logic [4:0] ptr_d, ptr_q;
  logic       rd_valid_d, rd_valid_q;
  logic [7:0] rd_data_d, rd_data_q;
  logic [2:0] rd_row_d, rd_row_q;
  logic [2:0] rd_col_d, rd_col_q;
  logic       rd_last_d, rd_last_q;

  assign wr        = busy_flag && !op_done;
  assign enter_cap = wr && (state_q != StCapture);
  assign replay_go = (state_q == StHold) && rd_start && result_valid_q && (elem_count_q != 5'd0);
  assign consume   = (state_q == StRead) && rd_valid_q && rd_ready;
  assign product   = {3'b000, result_m} * {3'b000, result_n};
  assign mismatch  = product != {1'b0, elem_count_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // A new write always wins, aborting any hold or replay in progress.
  always_comb begin
    state_d = state_q;
    if (wr) begin
      state_d = StCapture;
    end else begin
      case (state_q)
        StCapture: if (op_done) state_d = StHold;
        StHold:    if (replay_go) state_d = StRead;
        StRead:    if (consume && rd_last_q) state_d = StHold;
        default:   state_d = state_q;
      endcase
    end
  end

  always_comb begin
    elem_count_d   = elem_count_q;
    result_valid_d = result_valid_q;
    ovf_d          = ovf_q;
    mismatch_d     = mismatch_q;
    err_d          = err_q;
    res_m_d        = res_m_q;
    res_n_d        = res_n_q;
    ptr_d          = ptr_q;
    rd_valid_d     = rd_valid_q;
    rd_data_d      = rd_data_q;
    rd_row_d       = rd_row_q;
    rd_col_d       = rd_col_q;
    rd_last_d      = rd_last_q;
    mem_we         = 1'b0;
    mem_addr       = elem_count_q;

    if (enter_cap) begin
      elem_count_d   = 5'd1;
      result_valid_d = 1'b0;
      ovf_d          = 1'b0;
      mismatch_d     = 1'b0;
      err_d          = 1'b0;
      rd_valid_d     = 1'b0;
      mem_we         = 1'b1;
      mem_addr       = 5'd0;
    end else if (state_q == StCapture) begin
      if (error_flag) err_d = 1'b1;
      if (wr) begin
        if (elem_count_q == 5'(MAX_ELEMS)) begin
          ovf_d = 1'b1;
        end else begin
          mem_we       = 1'b1;
          elem_count_d = elem_count_q + 5'd1;
        end
      end else if (op_done) begin
        res_m_d        = result_m;
        res_n_d        = result_n;
        mismatch_d     = mismatch;
        result_valid_d = !(mismatch || ovf_q || err_q || error_flag);
      end
    end else if (replay_go) begin
      ptr_d      = 5'd0;
      rd_valid_d = 1'b1;
      rd_data_d  = mem_q[0];
      rd_row_d   = 3'd0;
      rd_col_d   = 3'd0;
      rd_last_d  = (elem_count_q == 5'd1);
    end else if (consume) begin
      if (rd_last_q) begin
        rd_valid_d = 1'b0;
      end else begin
        ptr_d     = ptr_q + 5'd1;
        rd_data_d = mem_q[ptr_q + 5'd1];
        rd_last_d = ((ptr_q + 5'd1) == (elem_count_q - 5'd1));
        if (rd_col_q == (res_n_q - 3'd1)) begin
          rd_col_d = 3'd0;
          rd_row_d = rd_row_q + 3'd1;
        end else begin
          rd_col_d = rd_col_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      elem_count_q   <= '0;
      result_valid_q <= 1'b0;
      ovf_q          <= 1'b0;
      mismatch_q     <= 1'b0;
      err_q          <= 1'b0;
      res_m_q        <= '0;
      res_n_q        <= '0;
      ptr_q          <= '0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      rd_row_q       <= '0;
      rd_col_q       <= '0;
      rd_last_q      <= 1'b0;
    end else begin
      elem_count_q   <= elem_count_d;
      result_valid_q <= result_valid_d;
      ovf_q          <= ovf_d;
      mismatch_q     <= mismatch_d;
      err_q          <= err_d;
      res_m_q        <= res_m_d;
      res_n_q        <= res_n_d;
      ptr_q          <= ptr_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
      rd_row_q       <= rd_row_d;
      rd_col_q       <= rd_col_d;
      rd_last_q      <= rd_last_d;
    end
  end

  // Storage is deliberately not reset; only addresses below elem_count are meaningful.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[mem_addr] <= result_data;
  end

  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign rd_row        = rd_row_q;
  assign rd_col        = rd_col_q;
  assign rd_last       = rd_last_q;
  assign res_m         = res_m_q;
  assign res_n         = res_n_q;
  assign elem_count    = elem_count_q;
  assign result_valid  = result_valid_q;
  assign ovf_flag      = ovf_q;
  assign mismatch_flag = mismatch_q;
  assign err_flag      = err_q;

endmodule
